// File: rtl/golden_nonce_collector.sv
// -----------------------------------------------------------------------------
// golden_nonce_collector
//
// Reader end of the miner's golden-nonce result interface. Every change of the
// held golden_nonce value is treated as one hit; the hit value is corrected by
// subtracting NONCE_ADJ (mod 2^32) and queued in a small first-word-fall-through
// FIFO. The host drains the FIFO through a valid/ready pop handshake, so
// back-to-back hits survive a slowly polling host.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   golden_nonce in   held nonce from the miner; any value change is one hit
//   clear        in   one-cycle pulse: flush FIFO, clear overflow (new work)
//   nonce_out    out  head-of-FIFO corrected nonce (registered)
//   nonce_valid  out  nonce_out holds a valid entry (registered)
//   nonce_ready  in   host accepts nonce_out when nonce_valid && nonce_ready
//   count        out  number of stored entries, 0..DEPTH (registered)
//   overflow     out  sticky: a hit was dropped because the FIFO was full
//   drop_cnt     out  (only with GOLDEN_NONCE_DROP_CNT_EN) saturating count of
//                     dropped hits; overflow then means drop_cnt != 0
//
// Optional build macro: GOLDEN_NONCE_DROP_CNT_EN
// -----------------------------------------------------------------------------
module golden_nonce_collector #(
    parameter int          DEPTH     = 8,
    parameter int          AW        = 3,
    parameter logic [31:0] NONCE_ADJ = 32'd0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   golden_nonce,
    input  logic          clear,
    output logic [31:0]   nonce_out,
    output logic          nonce_valid,
    input  logic          nonce_ready,
    output logic [AW:0]   count,
    output logic          overflow
`ifdef GOLDEN_NONCE_DROP_CNT_EN
    ,
    output logic [15:0]   drop_cnt
`endif
);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [31:0]   prev_nonce_q, prev_nonce_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   nonce_out_q, nonce_out_d;
    logic          nonce_valid_q, nonce_valid_d;
    logic          overflow_q, overflow_d;
`ifdef GOLDEN_NONCE_DROP_CNT_EN
    logic [15:0]   drop_cnt_q, drop_cnt_d;
`endif

    logic          hit_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [31:0]   push_data_s;

    // Hit detection, FIFO pointer/count update and next registered outputs.
    always_comb begin
        prev_nonce_d  = golden_nonce;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        nonce_out_d   = nonce_out_q;
        nonce_valid_d = nonce_valid_q;
        overflow_d    = overflow_q;
`ifdef GOLDEN_NONCE_DROP_CNT_EN
        drop_cnt_d    = drop_cnt_q;
`endif

        // A change arriving together with clear belongs to the old work.
        hit_s       = (golden_nonce != prev_nonce_q) && !reset && !clear;
        full_s      = (count_q == FULL_CNT);
        pop_s       = nonce_valid_q && nonce_ready && !clear && !reset;
        // When full, a same-cycle pop frees the slot the hit needs.
        push_s      = hit_s && (!full_s || pop_s);
        drop_s      = hit_s && full_s && !pop_s;
        push_data_s = golden_nonce - NONCE_ADJ;

        if (clear) begin
            wr_ptr_d      = {AW{1'b0}};
            rd_ptr_d      = {AW{1'b0}};
            count_d       = {(AW + 1){1'b0}};
            nonce_out_d   = 32'd0;
            nonce_valid_d = 1'b0;
            overflow_d    = 1'b0;
`ifdef GOLDEN_NONCE_DROP_CNT_EN
            drop_cnt_d    = 16'd0;
`endif
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = push_data_s;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            // Fall-through: if the new head is the slot being written this
            // cycle, present the incoming data rather than the stale memory.
            if (push_s && (wr_ptr_q == rd_ptr_d)) begin
                nonce_out_d = push_data_s;
            end else begin
                nonce_out_d = mem_q[rd_ptr_d];
            end
            nonce_valid_d = (count_d != {(AW + 1){1'b0}});

`ifdef GOLDEN_NONCE_DROP_CNT_EN
            if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            overflow_d = (drop_cnt_d != 16'd0);
`else
            overflow_d = overflow_q | drop_s;
`endif
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_nonce_q  <= 32'd0;
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            count_q       <= {(AW + 1){1'b0}};
            nonce_out_q   <= 32'd0;
            nonce_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
`ifdef GOLDEN_NONCE_DROP_CNT_EN
            drop_cnt_q    <= 16'd0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            prev_nonce_q  <= prev_nonce_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            nonce_out_q   <= nonce_out_d;
            nonce_valid_q <= nonce_valid_d;
            overflow_q    <= overflow_d;
`ifdef GOLDEN_NONCE_DROP_CNT_EN
            drop_cnt_q    <= drop_cnt_d;
`endif
            mem_q         <= mem_d;
        end
    end

    assign nonce_out   = nonce_out_q;
    assign nonce_valid = nonce_valid_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
`ifdef GOLDEN_NONCE_DROP_CNT_EN
    assign drop_cnt    = drop_cnt_q;
`endif

endmodule

// File: tb/tb_golden_nonce_collector.sv
// -----------------------------------------------------------------------------
// Bench for golden_nonce_collector (DEPTH=8, NONCE_ADJ=2). A queue-based
// reference model tracks expected contents; a compare process checks every
// output at each falling edge, and directed steps check hand-computed literals.
// -----------------------------------------------------------------------------
module tb_golden_nonce_collector;

    localparam int          DEPTH = 8;
    localparam int          AW    = 3;
    localparam logic [31:0] ADJ   = 32'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   golden_nonce;
    logic          clear;
    logic [31:0]   nonce_out;
    logic          nonce_valid;
    logic          nonce_ready;
    logic [AW:0]   count;
    logic          overflow;
`ifdef GOLDEN_NONCE_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int checks = 0;
    int passed = 0;

    // reference model state
    logic [31:0] mq[$];
    logic [31:0] m_prev;
    logic        m_ovf;
    int          m_drop;
    bit          checking = 1'b0;

    golden_nonce_collector #(
        .DEPTH(DEPTH),
        .AW(AW),
        .NONCE_ADJ(ADJ)
    ) dut (
        .clk(clk),
        .reset(reset),
        .golden_nonce(golden_nonce),
        .clear(clear),
        .nonce_out(nonce_out),
        .nonce_valid(nonce_valid),
        .nonce_ready(nonce_ready),
        .count(count),
        .overflow(overflow)
`ifdef GOLDEN_NONCE_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: apply the collector's rules to a plain queue at each rising edge.
    task automatic model_step();
        bit hit, pop, full;
        if (reset) begin
            mq.delete();
            m_prev   = 32'd0;
            m_ovf    = 1'b0;
            m_drop   = 0;
            checking = 1'b1;
        end else if (clear) begin
            mq.delete();
            m_prev = golden_nonce;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            hit  = (golden_nonce != m_prev);
            full = (mq.size() == DEPTH);
            pop  = (mq.size() != 0) && nonce_ready;
            if (pop) void'(mq.pop_front());
            if (hit) begin
                if (!full || pop) mq.push_back(golden_nonce - ADJ);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
            m_prev = golden_nonce;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare every output against the model each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                check("m_valid", {31'd0, nonce_valid}, {31'd0, mq.size() != 0});
                check("m_count", {28'd0, count}, 32'(mq.size()));
                check("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
                if (mq.size() != 0) check("m_nonce_out", nonce_out, mq[0]);
`ifdef GOLDEN_NONCE_DROP_CNT_EN
                check("m_drop_cnt", {16'd0, drop_cnt}, 32'(m_drop));
`endif
            end
        end
    end

    initial begin
        reset        = 1'b1;
        golden_nonce = 32'd0;
        clear        = 1'b0;
        nonce_ready  = 1'b0;
        tick(2);
        check("rst_valid", {31'd0, nonce_valid}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_out", nonce_out, 32'd0);
        reset = 1'b0;

        // golden_nonce held at 0 after reset is not a hit
        tick(10);
        check("idle_valid", {31'd0, nonce_valid}, 32'd0);
        check("idle_count", {28'd0, count}, 32'd0);
        check("idle_ovf", {31'd0, overflow}, 32'd0);

        // single hit with offset correction, then one pop
        golden_nonce = 32'h0000_1234;
        tick(1);
        check("hit_valid", {31'd0, nonce_valid}, 32'd1);
        check("hit_out", nonce_out, 32'h0000_1232);
        check("hit_count", {28'd0, count}, 32'd1);
        tick(2);
        check("hold_out", nonce_out, 32'h0000_1232);
        nonce_ready = 1'b1;
        tick(1);
        nonce_ready = 1'b0;
        check("pop_valid", {31'd0, nonce_valid}, 32'd0);
        check("pop_count", {28'd0, count}, 32'd0);

        // correction wraps modulo 2^32
        golden_nonce = 32'h0000_0001;
        tick(1);
        check("wrap_out", nonce_out, 32'hFFFF_FFFF);
        // ready while empty after this pop must not underflow
        nonce_ready = 1'b1;
        tick(3);
        nonce_ready = 1'b0;
        check("empty_count", {28'd0, count}, 32'd0);

        // fill past full: values 1..10, two dropped
        clear        = 1'b1;
        golden_nonce = 32'd0;
        tick(1);
        clear = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            golden_nonce = 32'(i);
            tick(1);
        end
        check("full_count", {28'd0, count}, 32'd8);
        check("full_ovf", {31'd0, overflow}, 32'd1);
        check("full_head", nonce_out, 32'hFFFF_FFFF);
`ifdef GOLDEN_NONCE_DROP_CNT_EN
        check("full_drop_cnt", {16'd0, drop_cnt}, 32'd2);
`endif
        nonce_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", nonce_out, 32'(i) - 32'd2);
            tick(1);
        end
        nonce_ready = 1'b0;
        check("drain_count", {28'd0, count}, 32'd0);
        check("drain_ovf_sticky", {31'd0, overflow}, 32'd1);

        // full FIFO, hit with simultaneous pop is accepted
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            golden_nonce = 32'd20 + 32'(i);
            tick(1);
        end
        golden_nonce = 32'd100;
        nonce_ready  = 1'b1;
        tick(1);
        nonce_ready = 1'b0;
        check("pp_count", {28'd0, count}, 32'd8);
        check("pp_ovf", {31'd0, overflow}, 32'd0);
        nonce_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("pp_order", nonce_out, (i < 7) ? (32'd19 + 32'(i)) : 32'd98);
            tick(1);
        end
        nonce_ready = 1'b0;

        // clear together with a nonce change discards the change
        for (int i = 0; i < 3; i++) begin
            golden_nonce = 32'd200 + 32'(i);
            tick(1);
        end
        check("q3_count", {28'd0, count}, 32'd3);
        clear        = 1'b1;
        golden_nonce = 32'd300;
        nonce_ready  = 1'b1;
        tick(1);
        clear       = 1'b0;
        nonce_ready = 1'b0;
        check("clr_count", {28'd0, count}, 32'd0);
        check("clr_valid", {31'd0, nonce_valid}, 32'd0);
        check("clr_ovf2", {31'd0, overflow}, 32'd0);
        tick(3);
        check("clr_no_hit", {28'd0, count}, 32'd0);

        // reset mid-operation loses queued entries
        golden_nonce = 32'd400;
        tick(1);
        golden_nonce = 32'd401;
        tick(1);
        check("pre_rst_count", {28'd0, count}, 32'd2);
        reset        = 1'b1;
        golden_nonce = 32'd0;
        tick(1);
        reset = 1'b0;
        check("mid_rst_count", {28'd0, count}, 32'd0);
        check("mid_rst_valid", {31'd0, nonce_valid}, 32'd0);
        tick(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
